noc_switch_allocator: RTL and testbench
=======================================

Name: noc_switch_allocator

Overview:
Output-port allocator for the 5-port NoC router (N, S, E, W, L). Each input port offers one flit per cycle tagged with its destination output. Per output, the block picks one requesting input by round-robin and holds that output for the whole packet, head flit through tail flit (wormhole). It drives the crossbar select lines and returns per-input accept strobes.

Parameters:
NUM_PORTS, 5, number of router ports; port index N=0, S=1, E=2, W=3, L=4
PORT_W, 3, width of an encoded port index

Ports:
clk  in  1  clock
rst  in  1  reset, synchronous, active-high
req_valid_i  in  NUM_PORTS  input p offers a flit this cycle
req_dest_i  in  NUM_PORTS x PORT_W  requested output index per input
req_tail_i  in  NUM_PORTS  offered flit is a tail flit (single-flit packet: tail=1)
out_ready_i  in  NUM_PORTS  downstream of output o can accept a flit
xbar_sel_o  out  NUM_PORTS x NUM_PORTS  per output o, one-hot input select (all-zero = idle)
in_accept_o  out  NUM_PORTS  input p's flit transfers this cycle
out_lock_o  out  NUM_PORTS  output o is held by an in-progress packet
err_o  out  1  sticky protocol-error flag

Behaviour:
- State per output o: lock[o] (1 bit), owner[o] (PORT_W bits), ptr[o] (PORT_W bits, round-robin start). Also err (1 bit).
- Reset: lock=0, owner=0, ptr[o]=o (staggered), err=0. While rst=1, xbar_sel_o=0, in_accept_o=0, out_lock_o=0, err_o=0.
- Grant decision is combinational from inputs and registered state, so a flit is accepted in the same cycle it is offered (zero latency). State updates on posedge clk.
- Candidate set for output o: inputs p with req_valid_i[p]=1 and req_dest_i[p]=o.
- Unlocked output:
  - Winner = first candidate scanning p = ptr[o], ptr[o]+1, ... mod 5.
  - Grant only if out_ready_i[o]=1. Otherwise xbar_sel_o[o]=0 and state is unchanged.
- Locked output:
  - Only owner[o] is eligible. Grant when that owner is a candidate and out_ready_i[o]=1.
  - Other candidates are never granted.
- Transfer: xbar_sel_o[o][p]=1 implies in_accept_o[p]=1, and this is the only way in_accept_o[p] is set. Each input names one output, so no input receives two grants.
- On a transfer at output o from input p:
  - Non-tail flit: lock[o]=1, owner[o]=p (lock already held: unchanged).
  - Tail flit: lock[o]=0 and ptr[o]=(p+1) mod 5.
  - A single-flit packet therefore never sets the lock, but it does advance ptr.
- Pointer moves only on a tail transfer (packet-granular fairness), never on a stalled cycle.
- Owner deasserts req_valid_i mid-packet: the output stays locked and idle (bubble) and keeps waiting for that owner.
- out_ready_i[o]=0 while locked: no grant, lock is held, nothing is dropped.
- Simultaneous events: all 5 outputs are allocated independently in the same cycle. A tail transfer and a new head on the same output never both happen in one cycle; the new packet is arbitrated in the next cycle.
- Errors set err (sticky until rst); the request involved is never granted:
  - req_valid_i[p]=1 with req_dest_i[p] >= 5.
  - Input p owns a locked output o and requests a different output o' != o with valid=1. This request is not granted at o' either.
- Reset mid-packet: all locks are cleared immediately. The upstream router is required to reset together with this block.

Decomposition:
- Shared package noc_pkg:
  - NUM_PORTS, PORT_W.
  - Enum port_e {PORT_N, PORT_S, PORT_E, PORT_W, PORT_L}.
  - Type port_mask_t as logic [NUM_PORTS-1:0].
- Sub-module noc_rr_arbiter, one instance per output:
  - Inputs: request mask, out_ready, tail-per-input, lock/owner/ptr state.
  - Produces the one-hot grant and the next lock/owner/ptr.
- The top level builds the request masks, checks errors, and ORs grants into in_accept_o.

Test Plan:
- Reset, then inputs N, E and L all request output S with single-flit packets every cycle and out_ready=1 -> grants at S go E, L, N, E, ... (ptr[S] starts at 1, so E wins first); each input accepted once every 3 cycles.
- Input W sends a 4-flit packet to L (tail on flit 4) while N requests L from cycle 1 -> xbar_sel_o[L] selects W for 4 consecutive cycles, out_lock_o[L]=1 from after flit 1 until after flit 4; N granted in cycle 5; ptr[L]=4 after W's tail.
- Locked packet W->E, out_ready_i[E] held 0 for 3 cycles mid-packet -> no accepts, lock held, owner=W; transfer resumes when ready returns, no flit lost or duplicated.
- Owner drops valid for 2 cycles mid-packet while S also requests the same output -> output idle both cycles, S not granted until owner's tail transfers.
- req_dest_i=5 on input N -> in_accept_o[N]=0, err_o=1 next cycle and stays 1; rst clears it to 0.
- All 5 inputs send to 5 distinct outputs in the same cycle -> all 5 in_accept_o bits =1 in that cycle, xbar_sel_o is a permutation.

Source files
------------

// File: rtl/noc_pkg.sv
// Shared constants and types for the 5-port NoC router.
package noc_pkg;

  localparam int unsigned NUM_PORTS = 5;
  localparam int unsigned PORT_W    = 3;

  typedef enum logic [PORT_W-1:0] {
    PORT_NORTH,
    PORT_SOUTH,
    PORT_EAST,
    PORT_WEST,
    PORT_LOCAL
  } port_e;

  typedef logic [NUM_PORTS-1:0] port_mask_t;
  typedef logic [PORT_W-1:0]    port_idx_t;

  // Increment modulo NUM_PORTS.
  function automatic port_idx_t next_port(input port_idx_t p);
    return (p == port_idx_t'(PORT_LOCAL)) ? '0 : p + port_idx_t'(1);
  endfunction

endpackage

// File: rtl/noc_rr_arbiter.sv
// Per-output wormhole round-robin arbiter: combinational grant plus next lock/owner/ptr.
module noc_rr_arbiter
  import noc_pkg::*;
(
  input  port_mask_t req,
  input  logic       ready,
  input  port_mask_t tail,
  input  logic       lock,
  input  port_idx_t  owner,
  input  port_idx_t  ptr,
  output port_mask_t gnt,
  output logic       lock_nxt,
  output port_idx_t  owner_nxt,
  output port_idx_t  ptr_nxt
);

  port_idx_t scan;
  port_idx_t win;
  logic      found;

  always_comb begin
    gnt   = '0;
    win   = owner;
    found = 1'b0;
    scan  = ptr;
    if (lock) begin
      found = req[owner];
    end else begin
      for (int i = 0; i < NUM_PORTS; i++) begin
        if (!found && req[scan]) begin
          found = 1'b1;
          win   = scan;
        end
        scan = next_port(scan);
      end
    end
    if (found && ready) begin
      gnt[win] = 1'b1;
    end

    lock_nxt  = lock;
    owner_nxt = owner;
    ptr_nxt   = ptr;
    // Pointer only moves at packet end, so fairness is per packet, not per flit.
    if (|gnt) begin
      if (tail[win]) begin
        lock_nxt = 1'b0;
        ptr_nxt  = next_port(win);
      end else begin
        lock_nxt  = 1'b1;
        owner_nxt = win;
      end
    end
  end

endmodule

// File: rtl/noc_switch_allocator.sv
// Output-port switch allocator: builds per-output request masks, flags protocol errors,
// and merges per-output grants into crossbar selects and input accepts.
module noc_switch_allocator
  import noc_pkg::*;
(
  input  logic                                clk,
  input  logic                                rst,
  input  port_mask_t                          req_valid_i,
  input  logic [NUM_PORTS-1:0][PORT_W-1:0]    req_dest_i,
  input  port_mask_t                          req_tail_i,
  input  port_mask_t                          out_ready_i,
  output logic [NUM_PORTS-1:0][NUM_PORTS-1:0] xbar_sel_o,
  output port_mask_t                          in_accept_o,
  output port_mask_t                          out_lock_o,
  output logic                                err_o
);

  port_mask_t lock_q;
  port_idx_t  owner_q [NUM_PORTS];
  port_idx_t  ptr_q   [NUM_PORTS];
  logic       err_q;

  logic       lock_d  [NUM_PORTS];
  port_idx_t  owner_d [NUM_PORTS];
  port_idx_t  ptr_d   [NUM_PORTS];
  logic       err_d;

  port_mask_t bad_dest;
  port_mask_t conflict;
  port_mask_t req_mask [NUM_PORTS];
  port_mask_t gnt      [NUM_PORTS];

  // An input that owns a locked output may only address that output.
  always_comb begin
    bad_dest = '0;
    conflict = '0;
    for (int p = 0; p < NUM_PORTS; p++) begin
      bad_dest[p] = req_valid_i[p] && (req_dest_i[p] >= port_idx_t'(NUM_PORTS));
      for (int o = 0; o < NUM_PORTS; o++) begin
        if (lock_q[o] && (owner_q[o] == port_idx_t'(p)) && req_valid_i[p] &&
            (req_dest_i[p] != port_idx_t'(o))) begin
          conflict[p] = 1'b1;
        end
      end
    end
    err_d = err_q | (|bad_dest) | (|conflict);
  end

  always_comb begin
    for (int o = 0; o < NUM_PORTS; o++) begin
      req_mask[o] = '0;
      for (int p = 0; p < NUM_PORTS; p++) begin
        req_mask[o][p] = req_valid_i[p] && !bad_dest[p] && !conflict[p] &&
                         (req_dest_i[p] == port_idx_t'(o));
      end
    end
  end

  for (genvar o = 0; o < NUM_PORTS; o++) begin : g_arb
    noc_rr_arbiter u_arb (
      .req       (req_mask[o]),
      .ready     (out_ready_i[o]),
      .tail      (req_tail_i),
      .lock      (lock_q[o]),
      .owner     (owner_q[o]),
      .ptr       (ptr_q[o]),
      .gnt       (gnt[o]),
      .lock_nxt  (lock_d[o]),
      .owner_nxt (owner_d[o]),
      .ptr_nxt   (ptr_d[o])
    );
  end

  always_comb begin
    xbar_sel_o  = '0;
    in_accept_o = '0;
    if (!rst) begin
      for (int o = 0; o < NUM_PORTS; o++) begin
        xbar_sel_o[o] = gnt[o];
        in_accept_o   = in_accept_o | gnt[o];
      end
    end
  end

  assign out_lock_o = rst ? '0 : lock_q;
  assign err_o      = err_q & ~rst;

  always_ff @(posedge clk) begin
    if (rst) begin
      lock_q <= '0;
      err_q  <= 1'b0;
      for (int o = 0; o < NUM_PORTS; o++) begin
        owner_q[o] <= '0;
        ptr_q[o]   <= port_idx_t'(o);
      end
    end else begin
      err_q <= err_d;
      for (int o = 0; o < NUM_PORTS; o++) begin
        lock_q[o]  <= lock_d[o];
        owner_q[o] <= owner_d[o];
        ptr_q[o]   <= ptr_d[o];
      end
    end
  end

endmodule

// File: tb/tb_noc_switch_allocator.sv
// Directed bench for noc_switch_allocator with hand-computed expectations.
module tb_noc_switch_allocator;
  import noc_pkg::*;

  logic                                clk = 1'b0;
  logic                                rst;
  port_mask_t                          req_valid;
  logic [NUM_PORTS-1:0][PORT_W-1:0]    req_dest;
  port_mask_t                          req_tail;
  port_mask_t                          out_ready;
  logic [NUM_PORTS-1:0][NUM_PORTS-1:0] xbar_sel;
  port_mask_t                          in_accept;
  port_mask_t                          out_lock;
  logic                                err;

  int vectors = 0;
  int miscompares = 0;

  logic [31:0] rr_exp [4] = '{32'b00100, 32'b10000, 32'b00001, 32'b00100};
  logic [31:0] perm_exp;

  noc_switch_allocator dut (
    .clk         (clk),
    .rst         (rst),
    .req_valid_i (req_valid),
    .req_dest_i  (req_dest),
    .req_tail_i  (req_tail),
    .out_ready_i (out_ready),
    .xbar_sel_o  (xbar_sel),
    .in_accept_o (in_accept),
    .out_lock_o  (out_lock),
    .err_o       (err)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    vectors++;
    assert (obs === exp) else begin
      miscompares++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic clear();
    req_valid = '0;
    req_tail  = '0;
    req_dest  = '0;
  endtask

  task automatic req(input int p, input logic [2:0] d, input logic t);
    req_valid[p] = 1'b1;
    req_dest[p]  = d;
    req_tail[p]  = t;
  endtask

  task automatic step();
    @(negedge clk);
    clear();
  endtask

  initial begin
    rst       = 1'b1;
    out_ready = '1;
    clear();
    repeat (2) @(negedge clk);
    req(0, 3'd1, 1'b1);
    req(2, 3'd1, 1'b1);
    #1;
    chk("rst_xbar", 32'(xbar_sel), 32'h0);
    chk("rst_accept", 32'(in_accept), 32'h0);
    chk("rst_lock", 32'(out_lock), 32'h0);
    chk("rst_err", 32'(err), 32'h0);
    step();
    rst = 1'b0;
    #1;
    chk("post_rst_lock", 32'(out_lock), 32'h0);
    chk("post_rst_err", 32'(err), 32'h0);

    // N, E, L compete for S with single-flit packets; ptr[S] starts at S.
    for (int c = 0; c < 4; c++) begin
      step();
      req(0, 3'd1, 1'b1);
      req(2, 3'd1, 1'b1);
      req(4, 3'd1, 1'b1);
      #1;
      chk("rr_accept", 32'(in_accept), rr_exp[c]);
      chk("rr_sel_s", 32'(xbar_sel[1]), rr_exp[c]);
    end
    chk("rr_no_lock", 32'(out_lock), 32'h0);

    // E single flit to L moves ptr[L] to W, then W wormhole of 4 flits against N.
    step();
    req(2, 3'd4, 1'b1);
    #1;
    chk("pre_worm_sel", 32'(xbar_sel[4]), 32'b00100);
    for (int c = 0; c < 4; c++) begin
      step();
      req(3, 3'd4, c == 3);
      req(0, 3'd4, 1'b1);
      #1;
      chk("worm_sel", 32'(xbar_sel[4]), 32'b01000);
      chk("worm_lock", 32'(out_lock), (c == 0) ? 32'h0 : 32'b10000);
    end
    step();
    req(0, 3'd4, 1'b1);
    req(2, 3'd4, 1'b1);
    #1;
    chk("worm_unlock", 32'(out_lock), 32'h0);
    chk("worm_next_sel", 32'(xbar_sel[4]), 32'b00001);
    chk("worm_next_acc", 32'(in_accept), 32'b00001);

    // W -> E packet with backpressure mid-packet.
    step();
    req(3, 3'd2, 1'b0);
    #1;
    chk("bp_head", 32'(in_accept), 32'b01000);
    for (int c = 0; c < 3; c++) begin
      step();
      out_ready[2] = 1'b0;
      req(3, 3'd2, 1'b0);
      #1;
      chk("bp_stall_acc", 32'(in_accept), 32'h0);
      chk("bp_stall_lock", 32'(out_lock), 32'b00100);
    end
    out_ready = '1;
    step();
    req(3, 3'd2, 1'b0);
    #1;
    chk("bp_resume", 32'(xbar_sel[2]), 32'b01000);
    step();
    req(3, 3'd2, 1'b1);
    #1;
    chk("bp_tail", 32'(in_accept), 32'b01000);
    step();
    #1;
    chk("bp_unlock", 32'(out_lock), 32'h0);

    // L owns W and bubbles for 2 cycles while S waits.
    step();
    req(4, 3'd3, 1'b0);
    req(1, 3'd3, 1'b1);
    #1;
    chk("bub_head", 32'(xbar_sel[3]), 32'b10000);
    for (int c = 0; c < 2; c++) begin
      step();
      req(1, 3'd3, 1'b1);
      #1;
      chk("bub_idle_sel", 32'(xbar_sel[3]), 32'h0);
      chk("bub_idle_acc", 32'(in_accept), 32'h0);
      chk("bub_lock", 32'(out_lock), 32'b01000);
    end
    step();
    req(4, 3'd3, 1'b1);
    req(1, 3'd3, 1'b1);
    #1;
    chk("bub_tail", 32'(xbar_sel[3]), 32'b10000);
    step();
    req(1, 3'd3, 1'b1);
    #1;
    chk("bub_next", 32'(xbar_sel[3]), 32'b00010);
    chk("bub_unlock", 32'(out_lock), 32'h0);

    // N owns S, then asks for E: refused and flagged.
    step();
    req(0, 3'd1, 1'b0);
    #1;
    chk("cf_head", 32'(in_accept), 32'b00001);
    step();
    req(0, 3'd2, 1'b1);
    #1;
    chk("cf_refused", 32'(in_accept), 32'h0);
    chk("cf_err_pre", 32'(err), 32'h0);
    step();
    #1;
    chk("cf_err", 32'(err), 32'h1);
    chk("cf_lock", 32'(out_lock), 32'b00010);
    step();
    rst = 1'b1;
    #1;
    chk("cf_rst_err", 32'(err), 32'h0);
    step();
    rst = 1'b0;
    #1;
    chk("cf_rst_lock", 32'(out_lock), 32'h0);

    // Out-of-range destination.
    step();
    req(0, 3'd5, 1'b1);
    #1;
    chk("bad_accept", 32'(in_accept), 32'h0);
    chk("bad_xbar", 32'(xbar_sel), 32'h0);
    chk("bad_err_pre", 32'(err), 32'h0);
    step();
    #1;
    chk("bad_err", 32'(err), 32'h1);
    step();
    step();
    #1;
    chk("bad_err_sticky", 32'(err), 32'h1);
    step();
    rst = 1'b1;
    step();
    rst = 1'b0;
    #1;
    chk("bad_err_clr", 32'(err), 32'h0);

    // Full permutation in one cycle.
    step();
    req(0, 3'd1, 1'b1);
    req(1, 3'd2, 1'b1);
    req(2, 3'd3, 1'b1);
    req(3, 3'd4, 1'b1);
    req(4, 3'd0, 1'b1);
    #1;
    perm_exp = 32'({5'b01000, 5'b00100, 5'b00010, 5'b00001, 5'b10000});
    chk("perm_accept", 32'(in_accept), 32'b11111);
    chk("perm_xbar", 32'(xbar_sel), perm_exp);

    step();
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
